// File: rtl/logic_unit_pkg.sv
// ---------------------------------------------------------------------------
// logic_unit_pkg
// Shared constants for the logic-unit arbiter slice: opcode encodings,
// opcode width and the sequencer FSM state encoding.
// ---------------------------------------------------------------------------
package logic_unit_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_AND  = 3'd0;
   localparam logic [OP_W-1:0] OP_OR   = 3'd1;
   localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
   localparam logic [OP_W-1:0] OP_NAND = 3'd3;
   localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
   localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
   localparam logic [OP_W-1:0] OP_NOTA = 3'd6;
   localparam logic [OP_W-1:0] OP_NOTB = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/logic_unit.sv
// ---------------------------------------------------------------------------
// logic_unit
// Purely combinational W-bit bitwise logic unit.
// Ports:
//   op : opcode (see logic_unit_pkg), all eight codes legal
//   a  : operand A
//   b  : operand B
//   y  : result; NOT A / NOT B ignore the other operand
// ---------------------------------------------------------------------------
module logic_unit
   import logic_unit_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [OP_W-1:0] op,
   input  logic [W-1:0]    a,
   input  logic [W-1:0]    b,
   output logic [W-1:0]    y
);

   always_comb begin
      y = '0;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NAND: y = ~(a & b);
         OP_NOR:  y = ~(a | b);
         OP_XNOR: y = ~(a ^ b);
         OP_NOTA: y = ~a;
         OP_NOTB: y = ~b;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/logic_unit_arbiter.sv
// ---------------------------------------------------------------------------
// logic_unit_arbiter
// Round-robin arbiter and sequencer sharing one logic_unit among N
// requesters. One operation is in flight at a time: IDLE (grant/capture),
// EXEC (evaluate into rsp_data), RESP (hold result until accepted).
//
// Handshake rule (both request and response sides): a transfer happens on a
// rising clk edge where valid and ready are both 1. The source holds its
// payload stable while valid is high and ready is low; a requester may drop
// req_valid before it is granted.
//
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   req_valid   : per-requester request valid            [N]
//   req_ready   : per-requester grant, one-hot or zero   [N]
//   req_op      : packed opcodes, requester i at [3i+2:3i]
//   req_a/req_b : packed operands, requester i at [W*i+W-1:W*i]
//   rsp_valid   : result valid (state RESP)
//   rsp_ready   : downstream accepts result
//   rsp_data    : registered result
//   rsp_id      : requester that owns rsp_data
//   busy        : state is EXEC or RESP
//   op_count    : completed-response counter, wraps at 16 bits
//   dbg_state   : current FSM state encoding
// ---------------------------------------------------------------------------
module logic_unit_arbiter
   import logic_unit_pkg::*;
#(
   parameter  int W   = 8,
   parameter  int N   = 4,
   localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N-1:0]      req_valid,
   output logic [N-1:0]      req_ready,
   input  logic [OP_W*N-1:0] req_op,
   input  logic [W*N-1:0]    req_a,
   input  logic [W*N-1:0]    req_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [W-1:0]      rsp_data,
   output logic [IDW-1:0]    rsp_id,
   output logic              busy,
   output logic [15:0]       op_count,
   output logic [1:0]        dbg_state
);

   state_t          state;
   logic [IDW-1:0]  rr_ptr;
   logic [OP_W-1:0] op_r;
   logic [W-1:0]    a_r;
   logic [W-1:0]    b_r;
   logic [IDW-1:0]  id_r;

   logic            found;
   logic [IDW-1:0]  winner;
   logic [IDW-1:0]  winner_nxt;
   logic            accept;
   logic [OP_W-1:0] sel_op;
   logic [W-1:0]    sel_a;
   logic [W-1:0]    sel_b;
   logic [W-1:0]    lu_y;

   // Round-robin search starting at rr_ptr. rr_ptr + k never exceeds 2N-2,
   // so a single conditional subtract is enough to wrap the index.
   always_comb begin
      int idx;
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            winner = IDW'(idx);
         end
      end
   end

   // Grant only in IDLE. Gating with rst keeps req_ready low while reset is
   // held even though the state already reads IDLE.
   always_comb begin
      req_ready = '0;
      if (state == ST_IDLE && found && !rst) req_ready[winner] = 1'b1;
   end

   assign accept     = |(req_valid & req_ready);
   assign winner_nxt = (winner == IDW'(N - 1)) ? '0 : winner + IDW'(1);

   assign sel_op = req_op[OP_W*winner +: OP_W];
   assign sel_a  = req_a[W*winner +: W];
   assign sel_b  = req_b[W*winner +: W];

   logic_unit #(.W(W)) u_logic_unit (
      .op (op_r),
      .a  (a_r),
      .b  (b_r),
      .y  (lu_y)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         rr_ptr   <= '0;
         op_r     <= '0;
         a_r      <= '0;
         b_r      <= '0;
         id_r     <= '0;
         rsp_data <= '0;
         rsp_id   <= '0;
         op_count <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_r   <= sel_op;
                  a_r    <= sel_a;
                  b_r    <= sel_b;
                  id_r   <= winner;
                  rr_ptr <= winner_nxt;
                  state  <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               rsp_data <= lu_y;
               rsp_id   <= id_r;
               state    <= ST_RESP;
            end
            ST_RESP: begin
               // Returning to IDLE here means the next grant can only be
               // accepted on the following edge, never on the handshake edge.
               if (rsp_ready) begin
                  op_count <= op_count + 16'd1;
                  state    <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign rsp_valid = (state == ST_RESP);
   assign busy      = (state == ST_EXEC) || (state == ST_RESP);
   assign dbg_state = state;

endmodule
